// File: rtl/exp_datapath.sv
// Exponent datapath: A/B exponent and shift-amount registers, two 16-bit adders
// with selectable operands, and max/zero exponent flags.
module exp_datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic        fpuhold,
    input  logic        dprec,
    input  logic [10:0] a_in_exp,
    input  logic [10:0] b_in_exp,
    input  logic [1:0]  aexp_sel,
    input  logic [1:0]  bexp_sel,
    input  logic [15:0] excon,
    input  logic [5:0]  priout,
    input  logic [1:0]  mux1ad,
    input  logic [1:0]  mux2ad,
    input  logic [1:0]  mux2bd,
    input  logic        addtcin,
    input  logic        addlcin,
    input  logic [1:0]  muxaed,
    input  logic        muxbed,
    input  logic [1:0]  muxsad_a,
    output logic [15:0] aexp,
    output logic [15:0] bexp,
    output logic [15:0] sa,
    output logic [15:0] addtop,
    output logic [15:0] addlow,
    output logic        topsign,
    output logic        aele,
    output logic        bele,
    output logic        azle,
    output logic        bzle
);

    logic [15:0] op_x;
    logic [15:0] op_y;
    logic [15:0] op_z;

    always_comb begin
        unique case (mux1ad)
            2'd0:    op_x = ~excon;
            2'd1:    op_x = excon;
            2'd2:    op_x = bexp;
            default: op_x = '0;
        endcase
        unique case (mux2ad)
            2'd0:    op_y = excon;
            2'd1:    op_y = sa;
            2'd2:    op_y = aexp;
            default: op_y = '0;
        endcase
        unique case (mux2bd)
            2'd0:    op_z = ~excon;
            2'd1:    op_z = ~aexp;
            2'd2:    op_z = 16'h0001;
            default: op_z = '1;
        endcase
    end

    // Carry-out of both adders is intentionally dropped (mod 2^16 wrap).
    assign addtop  = op_x + op_y + {15'b0, addtcin};
    assign addlow  = op_z + aexp + {15'b0, addlcin};
    assign topsign = addtop[15];

    always_ff @(posedge clk) begin
        if (reset) begin
            aexp <= '0;
        end else if (!fpuhold) begin
            if (aexp_sel == 2'd1) begin
                aexp <= {8'h00, a_in_exp[7:0]};
            end else if (aexp_sel == 2'd2) begin
                aexp <= {5'h00, a_in_exp};
            end else begin
                unique case (muxaed)
                    2'd1:    aexp <= excon;
                    2'd2:    aexp <= addtop;
                    2'd3:    aexp <= addlow;
                    default: aexp <= aexp;
                endcase
            end
        end
    end

    // bexp copies the pre-edge aexp, so a same-edge aexp load is not seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            bexp <= '0;
        end else if (!fpuhold) begin
            if (bexp_sel == 2'd1) begin
                bexp <= {8'h00, b_in_exp[7:0]};
            end else if (bexp_sel == 2'd2) begin
                bexp <= {5'h00, b_in_exp};
            end else if (muxbed) begin
                bexp <= aexp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sa <= '0;
        end else if (!fpuhold) begin
            unique case (muxsad_a)
                2'd0:    sa <= {10'b0, dprec, 5'h1F};
                2'd1:    sa <= {10'b0, priout};
                2'd2:    sa <= excon;
                default: sa <= sa;
            endcase
        end
    end

    assign aele = dprec ? (aexp[10:0] == 11'h7FF)
                        : (aexp[7:0] == 8'hFF && aexp[15:8] == 8'h00);
    assign bele = dprec ? (bexp[10:0] == 11'h7FF)
                        : (bexp[7:0] == 8'hFF && bexp[15:8] == 8'h00);
    assign azle = (aexp == '0);
    assign bzle = (bexp == '0);

endmodule
